// File: rtl/npu_pkg.sv
// Shared constants and helpers for the NPU compressor / adder-tree blocks.
package npu_pkg;

  localparam int unsigned POPC_BYTE_W = 8;
  localparam int unsigned POPC_CNT_W  = 4;

  // Ceiling log2; clog2(1) = 0, clog2(65) = 7.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/popcount8.sv
// Combinational 8-bit ones counter built as a full/half-adder compressor tree.
module popcount8
  import npu_pkg::*;
(
  input  logic [POPC_BYTE_W-1:0] data,
  output logic [POPC_CNT_W-1:0]  count
);

  // {carry, sum}
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  logic [1:0] t0, t1, t2, t3, t4, t5, t6;

  always_comb begin
    // weight-1 column
    t0 = fa(data[0], data[1], data[2]);
    t1 = fa(data[3], data[4], data[5]);
    t2 = ha(data[6], data[7]);
    t3 = fa(t0[0], t1[0], t2[0]);
    // weight-2 column: four carries
    t4 = fa(t0[1], t1[1], t2[1]);
    t5 = ha(t4[0], t3[1]);
    // weight-4 column
    t6 = ha(t4[1], t5[1]);
    count = {t6[1], t6[0], t5[0], t3[0]};
  end

endmodule

// File: rtl/popcount_accum.sv
// Three-stage popcount accumulator: per-byte counts, beat sum, saturating packet accumulator.
module popcount_accum
  import npu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_weight,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int unsigned NB    = WIDTH / POPC_BYTE_W;
  localparam int unsigned SUM_W = clog2(WIDTH + 1);

  logic                             stall_c;
  logic [WIDTH-1:0]                 operand_c;
  logic [NB-1:0][POPC_CNT_W-1:0]    cnt_c;
  logic [NB-1:0][POPC_CNT_W-1:0]    cnt1;
  logic                             v1, l1;
  logic [SUM_W-1:0]                 sum_c;
  logic [SUM_W-1:0]                 sum2;
  logic                             v2, l2;
  logic [ACC_W-1:0]                 acc;
  logic                             sticky;
  logic [ACC_W:0]                   next_c;
  logic                             ovf_c;
  logic [ACC_W-1:0]                 result_c;

  // Global stall: a pending total that downstream refuses freezes every stage.
  assign stall_c  = out_valid && !out_ready;
  assign in_ready = !stall_c;

  assign operand_c = in_mode ? ~(in_data ^ in_weight) : in_data;

  for (genvar g = 0; g < NB; g++) begin : g_byte
    popcount8 u_pc8 (
      .data  (operand_c[g*POPC_BYTE_W +: POPC_BYTE_W]),
      .count (cnt_c[g])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NB; i++) sum_c = sum_c + SUM_W'(cnt1[i]);
  end

  // Both addends fit in ACC_W bits, so the extra top bit is exactly the overflow.
  assign next_c   = {1'b0, acc} + (ACC_W+1)'(sum2);
  assign ovf_c    = next_c[ACC_W];
  assign result_c = ovf_c ? {ACC_W{1'b1}} : next_c[ACC_W-1:0];

  // S1 and S2 pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      l1   <= 1'b0;
      cnt1 <= '0;
      v2   <= 1'b0;
      l2   <= 1'b0;
      sum2 <= '0;
    end else if (!stall_c) begin
      v1   <= in_valid;
      l1   <= in_last;
      cnt1 <= cnt_c;
      v2   <= v1;
      l2   <= l1;
      sum2 <= sum_c;
    end
  end

  // S3 accumulator and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (!stall_c) begin
      out_valid <= v2 && l2;
      if (v2) begin
        if (l2) begin
          out_sum <= result_c;
          out_sat <= sticky | ovf_c;
          acc     <= '0;
          sticky  <= 1'b0;
        end else begin
          acc     <= result_c;
          sticky  <= sticky | ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Directed + randomized bench for popcount_accum; two instances (ACC_W=16 and ACC_W=8) share stimulus.
module tb_popcount_accum;

  typedef struct {
    int unsigned sum;
    bit          sat;
  } total_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [63:0] in_weight = '0;
  logic        in_mode = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_sum;
  logic        in_ready8, out_valid8, out_sat8;
  logic [7:0]  out_sum8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  longint unsigned tot = 0;
  total_t q16[$];
  total_t q8[$];
  int rets[$];

  always #5 clk = ~clk;

  popcount_accum #(.WIDTH(64), .ACC_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat)
  );

  popcount_accum #(.WIDTH(64), .ACC_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_weight(in_weight), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8), .out_sat(out_sat8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic total_t make_total(input longint unsigned t, input int unsigned w);
    total_t r;
    longint unsigned mx;
    mx = (longint'(1) << w) - 1;
    r.sum = int'(t > mx ? mx : t);
    r.sat = (t > mx);
    return r;
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, update the reference model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic [63:0] w,
                       input logic m, input logic l, input logic ordy, output logic acc);
    total_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_weight = w; in_mode = m; in_last = l; out_ready = ordy;
    #1;
    cyc++;
    chk("in_ready", in_ready, !(out_valid && !ordy));
    chk("in_ready8", in_ready8, !(out_valid8 && !ordy));
    if (out_valid) begin
      chk("pending16", q16.size() > 0, 1'b1);
      if (q16.size() > 0) begin
        e = q16[0];
        chk("sum16", out_sum, e.sum);
        chk("sat16", out_sat, e.sat);
        if (ordy) begin
          void'(q16.pop_front());
          rets.push_back(cyc);
        end
      end
    end
    if (out_valid8) begin
      chk("pending8", q8.size() > 0, 1'b1);
      if (q8.size() > 0) begin
        e = q8[0];
        chk("sum8", out_sum8, e.sum);
        chk("sat8", out_sat8, e.sat);
        if (ordy) void'(q8.pop_front());
      end
    end
    acc = v && in_ready;
    if (acc) begin
      tot += $countones(m ? ~(d ^ w) : d);
      if (l) begin
        q16.push_back(make_total(tot, 16));
        q8.push_back(make_total(tot, 8));
        tot = 0;
      end
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [63:0] w, input logic m,
                           input logic l, input bit rnd);
    logic a;
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, w, m, l, rnd ? logic'($urandom_range(0, 9) < 7) : 1'b1, a);
      n++;
    end while (!a && n < 50);
    chk("accept_bound", a, 1'b1);
  endtask

  task automatic drain();
    logic a;
    int n;
    n = 0;
    while ((q16.size() > 0 || q8.size() > 0) && n < 60) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
      n++;
    end
    chk("drain16", q16.size(), 0);
    chk("drain8", q8.size(), 0);
  endtask

  initial begin
    logic        a;
    logic [63:0] ones, d, w;
    int          c0, nstall, len;
    ones = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_sat", out_sat, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Single beat, latency 3
    cycle(1'b1, 64'hFFFF_0000_FFFF_0001, '0, 1'b0, 1'b1, 1'b1, a);
    chk("lat_accept", a, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("lat_c1", out_valid, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("lat_c2", out_valid, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("lat_c3", out_valid, 1'b1);
    chk("lat_sum33", out_sum, 33);
    drain();

    // XNOR mode: all match -> 256, then all mismatch -> 0
    for (int i = 0; i < 4; i++) send_beat('0, '0, 1'b1, i == 3, 1'b0);
    d = {$urandom, $urandom};
    send_beat(d, ~d, 1'b1, 1'b1, 1'b0);
    drain();

    // Back-to-back packets of 1 and 2 beats at full throughput
    rets.delete();
    c0 = cyc;
    send_beat(ones, '0, 1'b0, 1'b1, 1'b0);
    send_beat(ones, '0, 1'b0, 1'b0, 1'b0);
    send_beat(ones, '0, 1'b0, 1'b1, 1'b0);
    chk("b2b_cycles", cyc - c0, 3);
    drain();
    chk("b2b_count", rets.size(), 2);
    if (rets.size() == 2) chk("b2b_gap", rets[1] - rets[0], 2);

    // Downstream stall with upstream continuously offering
    send_beat(64'h00FF, '0, 1'b0, 1'b1, 1'b0);
    nstall = 0;
    d = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, d, '0, 1'b0, 1'b0, 1'b0, a);
      if (out_valid) begin
        nstall++;
        chk("stall_in_ready", in_ready, 1'b0);
      end
      if (a) d = {$urandom, $urandom};
    end
    chk("stall_cycles", nstall, 6);
    send_beat(d, '0, 1'b0, 1'b1, 1'b0);
    drain();

    // Saturation on the 8-bit accumulator: 192 fits, 320 saturates, then sticky clears
    for (int i = 0; i < 3; i++) send_beat(ones, '0, 1'b0, i == 2, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(ones, '0, 1'b0, i == 4, 1'b0);
    send_beat(64'h0101_0101_0101_0101, '0, 1'b0, 1'b1, 1'b0);
    drain();

    // Randomized packets with random backpressure
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        d = {$urandom, $urandom};
        w = {$urandom, $urandom};
        send_beat(d, w, 1'(($urandom) & 1), i == len - 1, 1'b1);
      end
    end
    drain();

    // Reset mid-packet discards the partial sum
    send_beat(ones, '0, 1'b0, 1'b0, 1'b0);
    send_beat(ones, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
      chk("rst_mid_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
      chk("post_rst_valid", out_valid, 1'b0);
    end
    send_beat(ones, '0, 1'b0, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
